// File: rtl/palette_ctrl.sv
// Double-buffered 24-bit colour palette: host writes a shadow bank, commit copies it to the
// active bank on the next frame_start. Optional fade scaling under `PALETTE_CTRL_FADE_EN.
module palette_ctrl #(
    parameter int IDX_W     = 3,
    parameter int FRAME_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [23:0]      wr_color,
    input  logic             commit,
    output logic             commit_pending,
    input  logic             frame_start,
    output logic             swap_done,
    input  logic [IDX_W-1:0] color_in,
    output logic [23:0]      color_out,
    input  logic [2:0]       fade_target,
    output logic             fade_busy
);

    localparam int DEPTH = 2 ** IDX_W;

    typedef enum logic {
        ST_OPEN,
        ST_LOCKED
    } state_t;

    function automatic logic [23:0] default_entry(input int idx);
        case (idx)
            1:       return 24'h030326;
            2:       return 24'h0a0a46;
            3:       return 24'h38383a;
            4:       return 24'h2d2621;
            6:       return 24'h241211;
            7:       return 24'h645f57;
            default: return 24'h000000;
        endcase
    endfunction

    state_t      state, state_nxt;
    logic        do_write, do_copy;
    logic [23:0] shadow_bank [DEPTH];
    logic [23:0] active_bank [DEPTH];
    logic [23:0] entry, swapped, color_nxt;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_OPEN;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt      = state;
        wr_ready       = 1'b0;
        commit_pending = 1'b0;
        do_write       = 1'b0;
        do_copy        = 1'b0;
        case (state)
            ST_OPEN: begin
                wr_ready = 1'b1;
                do_write = wr_valid;
                if (commit) state_nxt = ST_LOCKED;
            end
            ST_LOCKED: begin
                commit_pending = 1'b1;
                if (frame_start) begin
                    do_copy   = 1'b1;
                    state_nxt = ST_OPEN;
                end
            end
        endcase
    end

    // NOTE: both banks are register arrays with reset because reset must restore the default palette.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) shadow_bank[i] <= default_entry(i);
        end else if (do_write) begin
            shadow_bank[wr_index] <= wr_color;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) active_bank[i] <= default_entry(i);
        end else if (do_copy) begin
            for (int i = 0; i < DEPTH; i++) active_bank[i] <= shadow_bank[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) swap_done <= 1'b0;
        else     swap_done <= do_copy;
    end

    // A lookup in the copy cycle still reads the old active entry.
    assign entry   = active_bank[color_in];
    assign swapped = {entry[7:0], entry[15:8], entry[23:16]};

`ifdef PALETTE_CTRL_FADE_EN
    localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [2:0]       fade_level;
    logic [CNT_W-1:0] frame_cnt;
    logic             frame_wrap;

    assign frame_wrap = (frame_cnt == CNT_W'(FRAME_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            fade_level <= 3'd0;
            frame_cnt  <= '0;
        end else if (frame_start) begin
            if (frame_wrap) begin
                frame_cnt <= '0;
                if (fade_level < fade_target)      fade_level <= fade_level + 3'd1;
                else if (fade_level > fade_target) fade_level <= fade_level - 3'd1;
            end else begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    function automatic logic [7:0] scale(input logic [7:0] b, input logic [2:0] lvl);
        logic [10:0] prod;
        prod = 11'(b) * 11'(4'd8 - {1'b0, lvl});
        return prod[10:3];
    endfunction

    assign color_nxt = {scale(swapped[23:16], fade_level),
                        scale(swapped[15:8],  fade_level),
                        scale(swapped[7:0],   fade_level)};
    assign fade_busy = (fade_level != fade_target);
`else
    logic unused_fade_cfg;

    assign unused_fade_cfg = (^fade_target) ^ (FRAME_DIV == 0);
    assign color_nxt       = swapped;
    assign fade_busy       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) color_out <= 24'h000000;
        else     color_out <= color_nxt;
    end

endmodule
